// File: rtl/io_input_conditioner.sv
// Board-input front end: per-channel synchroniser, optional inversion,
// counter debouncer, edge pulses and software-clearable press flag.
module io_input_conditioner #(
  parameter int              N_CH         = 21,
  parameter int              SYNC_STAGES  = 2,
  parameter int              DEBOUNCE_CYC = 500000,
  parameter logic [N_CH-1:0] INV_MASK     = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_i,
  input  logic [N_CH-1:0] clr_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic [N_CH-1:0] sticky_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]   cnt_q  [N_CH];
  logic [N_CH-1:0] s;
  logic [N_CH-1:0] fire;
  logic [N_CH-1:0] rise_d;
  logic [N_CH-1:0] fall_d;

  // Sync flops reset to the mask so the inverted view starts at 0.
  assign s = sync_q[SYNC_STAGES-1] ^ INV_MASK;

  always_comb begin
    fire = '0;
    for (int i = 0; i < N_CH; i++) begin
      fire[i] = (s[i] != level_o[i]) && (cnt_q[i] == LAST);
    end
  end

  assign rise_d = fire & s;
  assign fall_d = fire & ~s;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= INV_MASK;
      end
    end else begin
      sync_q[0] <= raw_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Count only while the input disagrees with the accepted level.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if ((s[i] == level_o[i]) || fire[i]) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_o  <= '0;
      rise_o   <= '0;
      fall_o   <= '0;
      sticky_o <= '0;
    end else begin
      level_o  <= level_o ^ fire;
      rise_o   <= rise_d;
      fall_o   <= fall_d;
      sticky_o <= (sticky_o & ~clr_i) | rise_d;
    end
  end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner: directed scenarios plus random
// stimulus against a sliding-window reference model.
module tb_io_input_conditioner;

  localparam int         N   = 4;
  localparam int         S   = 2;
  localparam int         D   = 4;
  localparam logic [3:0] INV = 4'b1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] raw;
  logic [3:0] clr;
  logic [3:0] level;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] sticky;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_level, m_rise, m_fall, m_sticky;
  logic [3:0] pipe [$];
  logic [3:0] win [$];

  always #5 clk = ~clk;

  io_input_conditioner #(
    .N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYC(D), .INV_MASK(INV)
  ) dut (
    .clk(clk), .rst(rst), .raw_i(raw), .clr_i(clr),
    .level_o(level), .rise_o(rise), .fall_o(fall), .sticky_o(sticky)
  );

  // A level change is accepted once the last D samples all disagree.
  task automatic tick();
    logic [3:0] s_now;
    logic [3:0] acc;
    @(posedge clk);
    if (rst) begin
      m_level = '0; m_rise = '0; m_fall = '0; m_sticky = '0;
      pipe = {};
      win = {};
      repeat (S) pipe.push_back(INV);
      repeat (D) win.push_back(4'b0000);
    end else begin
      s_now = pipe[S-1] ^ INV;
      pipe.push_front(raw);
      void'(pipe.pop_back());
      win.push_back(s_now);
      void'(win.pop_front());
      acc = 4'b1111;
      foreach (win[k]) acc &= win[k] ^ m_level;
      m_rise   = acc & s_now;
      m_fall   = acc & ~s_now;
      m_level  = m_level ^ acc;
      m_sticky = (m_sticky & ~clr) | m_rise;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; raw = INV; clr = '0;
    repeat (3) tick();
    checks++;
    if ({level, rise, fall, sticky} !== 16'h0) begin
      errors++;
      $display("FAIL reset_vals got %h want 0000",
               {level, rise, fall, sticky});
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if ({level, rise, fall, sticky} !== 16'h0) begin
        errors++;
        $display("FAIL idle_after_reset k=%0d got %h want 0000",
                 k, {level, rise, fall, sticky});
      end
    end
  endtask

  task automatic test_rise();
    raw[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if ({level[0], rise[0], sticky[0]} !==
          {(k >= 6), (k == 6), (k >= 6)}) begin
        errors++;
        $display("FAIL rise_ch0 k=%0d got lvl/rise/stk %b%b%b want %b%b%b",
                 k, level[0], rise[0], sticky[0],
                 (k >= 6), (k == 6), (k >= 6));
      end
    end
  endtask

  task automatic test_bounce();
    logic [1:0] pat [4];
    int         len [4];
    pat[0] = 1; len[0] = 3;
    pat[1] = 0; len[1] = 1;
    pat[2] = 1; len[2] = 3;
    pat[3] = 0; len[3] = 8;
    for (int p = 0; p < 4; p++) begin
      raw[1] = pat[p][0];
      for (int k = 0; k < len[p]; k++) begin
        tick();
        checks++;
        if ({level[1], rise[1]} !== 2'b00) begin
          errors++;
          $display("FAIL bounce_ch1 p=%0d k=%0d got lvl/rise %b%b want 00",
                   p, k, level[1], rise[1]);
        end
      end
    end
  endtask

  task automatic test_key();
    raw[3] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if ({level[3], rise[3], fall[3]} !== {(k >= 6), (k == 6), 1'b0}) begin
        errors++;
        $display("FAIL key_press k=%0d got lvl/rise/fall %b%b%b", k,
                 level[3], rise[3], fall[3]);
      end
    end
    raw[3] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if ({level[3], rise[3], fall[3]} !== {(k < 6), 1'b0, (k == 6)}) begin
        errors++;
        $display("FAIL key_release k=%0d got lvl/rise/fall %b%b%b", k,
                 level[3], rise[3], fall[3]);
      end
    end
  endtask

  task automatic test_clr();
    raw[0] = 1'b0;
    repeat (8) tick();
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    checks++;
    if (sticky[0] !== 1'b0) begin
      errors++;
      $display("FAIL clr_plain got %b want 0", sticky[0]);
    end
    raw[0] = 1'b1;
    repeat (5) tick();
    clr[0] = 1'b1;
    tick();
    checks++;
    if ({rise[0], sticky[0]} !== 2'b11) begin
      errors++;
      $display("FAIL clr_vs_rise got rise/stk %b%b want 11",
               rise[0], sticky[0]);
    end
    tick();
    clr[0] = 1'b0;
    checks++;
    if ({rise[0], sticky[0]} !== 2'b00) begin
      errors++;
      $display("FAIL clr_next got rise/stk %b%b want 00",
               rise[0], sticky[0]);
    end
  endtask

  task automatic test_reset_mid();
    raw[2] = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({level, rise, fall} !== 12'h0) begin
      errors++;
      $display("FAIL mid_reset got %h want 000", {level, rise, fall});
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if ({rise[2], fall[2], level[2]} !== {(k == 6), 1'b0, (k >= 6)}) begin
        errors++;
        $display("FAIL post_reset_ch2 k=%0d got rise/fall/lvl %b%b%b",
                 k, rise[2], fall[2], level[2]);
      end
      checks++;
      if (fall !== 4'b0000) begin
        errors++;
        $display("FAIL post_reset_fall k=%0d got %b want 0000", k, fall);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 4) == 0) raw[b] = ~raw[b];
        clr[b] = ($urandom_range(0, 7) == 0);
      end
      rst = ($urandom_range(0, 149) == 0);
      tick();
      checks++;
      if ({level, rise, fall, sticky} !==
          {m_level, m_rise, m_fall, m_sticky}) begin
        errors++;
        $display("FAIL random k=%0d got l/r/f/s %b %b %b %b want %b %b %b %b",
                 k, level, rise, fall, sticky,
                 m_level, m_rise, m_fall, m_sticky);
      end
      checks++;
      if ((rise & fall) !== 4'b0000) begin
        errors++;
        $display("FAIL rise_and_fall k=%0d got %b want 0000", k, rise & fall);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rise();
    test_bounce();
    test_key();
    test_clr();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
